encoder_round_sequencer: RTL and testbench

- Top-level scheduler for the encoder permutation.
- Runs NUM_ROUNDS rounds. Each round starts N_STAGES stage blocks in fixed order (column parity, rotate, permute, revaluate, add-round-constant), one at a time, using each stage's start/ready handshake.
- Drives the round index to the round-constant stage and the ping-pong memory bank select shared by all stages.
- Monitors each stage with a watchdog timer.

---
 rtl/encoder_round_sequencer_pkg.sv | 28 ++
 rtl/encoder_round_sequencer_watchdog.sv | 46 ++++
 rtl/encoder_round_sequencer.sv | 135 +++++++++++++
 tb/tb_encoder_round_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_round_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// encoder_round_sequencer_pkg
//   Shared definitions for the encoder permutation scheduler:
//   - default stage / round counts
//   - stage index constants (execution order within a round)
//   - sequencer FSM state encoding
// ---------------------------------------------------------------------------
package encoder_round_sequencer_pkg;

    localparam int N_STAGES_DEF   = 5;
    localparam int NUM_ROUNDS_DEF = 24;

    // Stage blocks, launched in this order every round.
    localparam int STG_COLPAR = 0;
    localparam int STG_ROT    = 1;
    localparam int STG_PERM   = 2;
    localparam int STG_REVAL  = 3;
    localparam int STG_ADDRC  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_ARM    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/encoder_round_sequencer_watchdog.sv
// ---------------------------------------------------------------------------
// seq_watchdog
//   Per-stage timeout counter for the round sequencer.
//   Ports:
//     clk       system clock, rising edge
//     rst       asynchronous active-low reset
//     clr_i     synchronously clear the counter (stage launch)
//     en_i      count this cycle (sequencer waiting on a stage)
//     expire_o  this enabled cycle brings the count to its limit (2^TIMEOUT_W-1)
// ---------------------------------------------------------------------------
module seq_watchdog #(
    parameter int TIMEOUT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = '1;

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count includes the current waiting cycle, so the limit is reached
    // on the cycle whose increment lands on LIMIT.
    assign expire_o = en_i && (cnt_q == LIMIT - TIMEOUT_W'(1));

endmodule

// File: rtl/encoder_round_sequencer.sv
// ---------------------------------------------------------------------------
// encoder_round_sequencer
//   Top-level scheduler for the encoder permutation. Runs NUM_ROUNDS rounds;
//   each round launches N_STAGES stage blocks one at a time via a start/ready
//   handshake, ping-pongs the shared memory bank after every stage and guards
//   each stage with a watchdog.
//   Ports:
//     clk          system clock, rising edge
//     rst          asynchronous active-low reset
//     start        request an encode; only sampled in IDLE
//     stage_ready  level ready from each stage (1 = idle/finished)
//     stage_start  one-hot, single-cycle start pulse to the active stage
//     round_idx    current round, to the add-round-constant stage
//     bank_sel     source bank for the active stage (it writes !bank_sel)
//     ready        high in IDLE only
//     done         one-cycle pulse on normal completion
//     err          sticky watchdog error, cleared by the next accepted start
// ---------------------------------------------------------------------------
module encoder_round_sequencer
    import encoder_round_sequencer_pkg::*;
#(
    parameter int N_STAGES   = N_STAGES_DEF,
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int ROUND_W    = 5,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_STAGES-1:0] stage_ready,
    output logic [N_STAGES-1:0] stage_start,
    output logic [ROUND_W-1:0]  round_idx,
    output logic                bank_sel,
    output logic                ready,
    output logic                done,
    output logic                err
);

    localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam logic [SW-1:0]      STG_LAST = SW'(N_STAGES - 1);
    localparam logic [ROUND_W-1:0] RND_LAST = ROUND_W'(NUM_ROUNDS - 1);

    seq_state_e         state_q, state_d;
    logic [SW-1:0]      stg_q, stg_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               bank_q, bank_d;
    logic               err_q, err_d;
    logic               wd_expire;

    seq_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == ST_LAUNCH),
        .en_i     (state_q == ST_WAIT),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        round_d = round_q;
        bank_d  = bank_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    round_d = '0;
                    stg_d   = '0;
                    bank_d  = 1'b0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_ARM;
            // The stage only drops ready the cycle after it samples start,
            // so its ready bit is meaningless here.
            ST_ARM:    state_d = ST_WAIT;
            ST_WAIT: begin
                // Completion wins over a watchdog expiry in the same cycle.
                if (stage_ready[stg_q]) begin
                    bank_d = ~bank_q;
                    if (stg_q != STG_LAST) begin
                        stg_d   = stg_q + SW'(1);
                        state_d = ST_LAUNCH;
                    end else if (round_q != RND_LAST) begin
                        stg_d   = '0;
                        round_d = round_q + ROUND_W'(1);
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (wd_expire) begin
                    // round_idx / bank_sel left as-is for debug.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            stg_q   <= '0;
            round_q <= '0;
            bank_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            round_q <= round_d;
            bank_q  <= bank_d;
            err_q   <= err_d;
        end
    end

    // Moore outputs decoded from registers only; reset clears them at once.
    always_comb begin
        stage_start = '0;
        if (state_q == ST_LAUNCH) begin
            stage_start[stg_q] = 1'b1;
        end
    end

    assign round_idx = round_q;
    assign bank_sel  = bank_q;
    assign ready     = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_encoder_round_sequencer.sv
module tb_encoder_round_sequencer;

    localparam int NS = 5;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Big instance: defaults. Small instance: 1 round, 4-bit watchdog.
    logic          b_start, s_start;
    logic [NS-1:0] b_rdy, b_sst, s_rdy, s_sst;
    logic [RW-1:0] b_round, s_round;
    logic          b_bank, b_ready, b_done, b_err;
    logic          s_bank, s_ready, s_done, s_err;

    encoder_round_sequencer u_big (
        .clk(clk), .rst(rst), .start(b_start), .stage_ready(b_rdy),
        .stage_start(b_sst), .round_idx(b_round), .bank_sel(b_bank),
        .ready(b_ready), .done(b_done), .err(b_err)
    );

    encoder_round_sequencer #(.N_STAGES(NS), .NUM_ROUNDS(1), .ROUND_W(RW), .TIMEOUT_W(4)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .stage_ready(s_rdy),
        .stage_start(s_sst), .round_idx(s_round), .bank_sel(s_bank),
        .ready(s_ready), .done(s_done), .err(s_err)
    );

    // Stub stages: ready drops the cycle after start and stays low L cycles.
    int b_L = 3, s_L = 1;
    int b_cnt [NS] = '{default: 0};
    int s_cnt [NS] = '{default: 0};
    logic [NS-1:0] s_hang = '0;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (b_sst[i]) b_cnt[i] <= b_L;
            else if (b_cnt[i] > 0) b_cnt[i] <= b_cnt[i] - 1;
            if (s_sst[i]) s_cnt[i] <= s_L;
            else if (s_cnt[i] > 0) s_cnt[i] <= s_cnt[i] - 1;
        end
    end

    always_comb begin
        b_rdy = '0;
        s_rdy = '0;
        for (int i = 0; i < NS; i++) begin
            b_rdy[i] = (b_cnt[i] == 0);
            s_rdy[i] = (s_cnt[i] == 0) && !s_hang[i];
        end
    end

    // Launch monitors.
    typedef struct {int cyc; int stg; int rnd; bit bank;} launch_t;
    launch_t b_log[$];
    launch_t s_log[$];
    int b_done_cnt = 0, s_done_cnt = 0;

    function automatic int oh_idx(input logic [NS-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < NS; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (b_sst != '0) b_log.push_back('{cyc, oh_idx(b_sst), int'(b_round), b_bank});
        if (s_sst != '0) s_log.push_back('{cyc, oh_idx(s_sst), int'(s_round), s_bank});
        if (b_done === 1'b1) b_done_cnt++;
        if (s_done === 1'b1) s_done_cnt++;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {int L; bit exp_err; int exp_lat; bit exp_bank;} vec_t;
    vec_t tbl [5];

    initial begin
        bit ok;
        int endc, first, bad, nlog, dcnt;
        bit done_bank;

        // {stage latency, expect err, cycles from first launch to done/err, final bank}
        tbl = '{'{1, 1'b0, 15, 1'b1}, '{2, 1'b0, 20, 1'b1}, '{5, 1'b0, 35, 1'b1},
                '{15, 1'b0, 85, 1'b1}, '{16, 1'b1, 17, 1'b0}};

        b_start = 1'b0;
        s_start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", b_ready, 1);
        chk("rst_done", b_done, 0);
        chk("rst_err", b_err, 0);
        chk("rst_sst", b_sst, 0);
        chk("rst_round", b_round, 0);
        chk("rst_bank", b_bank, 0);
        rst = 1'b1;
        @(negedge clk);

        // Nominal run with start held during rounds 5 and 10
        b_L = 3;
        b_log.delete();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        ok = 0; endc = 0; done_bank = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (b_done) begin ok = 1; endc = cyc; done_bank = b_bank; break; end
            b_start = (b_round == 5 || b_round == 10);
        end
        b_start = 1'b0;
        chk("nom_done_seen", ok, 1);
        first = (b_log.size() > 0) ? b_log[0].cyc : -100000;
        chk("nom_latency", endc - first, 600);
        chk("nom_bank_at_done", done_bank, 0);
        @(negedge clk);
        chk("nom_ready_after", b_ready, 1);
        chk("nom_done_1cyc", b_done, 0);
        repeat (20) @(negedge clk);
        chk("nom_pulse_count", b_log.size(), 120);
        chk("nom_done_count", b_done_cnt, 1);
        bad = 0;
        foreach (b_log[i]) if (b_log[i].stg != i % 5 || b_log[i].rnd != i / 5) bad++;
        chk("nom_order_bad", bad, 0);

        // Table: small instance over several stage latencies
        foreach (tbl[t]) begin
            s_L = tbl[t].L;
            s_log.delete();
            s_start = 1'b1;
            @(negedge clk);
            s_start = 1'b0;
            chk($sformatf("tbl%0d_err_clr", t), s_err, 0);
            ok = 0; endc = 0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (s_done || s_err) begin ok = 1; endc = cyc; break; end
            end
            chk($sformatf("tbl%0d_end", t), ok, 1);
            first = (s_log.size() > 0) ? s_log[0].cyc : -100000;
            chk($sformatf("tbl%0d_err", t), s_err, tbl[t].exp_err);
            chk($sformatf("tbl%0d_lat", t), endc - first, tbl[t].exp_lat);
            chk($sformatf("tbl%0d_bank", t), s_bank, tbl[t].exp_bank);
            chk($sformatf("tbl%0d_round", t), s_round, 0);
            chk($sformatf("tbl%0d_nlaunch", t), s_log.size(), tbl[t].exp_err ? 1 : 5);
            bad = 0;
            foreach (s_log[i]) if (s_log[i].stg != i || s_log[i].bank != bit'(i % 2)) bad++;
            chk($sformatf("tbl%0d_launch_bad", t), bad, 0);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", t), s_ready, 1);
        end

        // Watchdog: stage 3 never comes back
        s_L = 1;
        s_hang = 5'b01000;
        s_log.delete();
        dcnt = s_done_cnt;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        ok = 0; endc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_err || s_done) begin ok = 1; endc = cyc; break; end
        end
        chk("wd_end", ok, 1);
        chk("wd_err", s_err, 1);
        chk("wd_ready", s_ready, 1);
        chk("wd_nlaunch", s_log.size(), 4);
        first = (s_log.size() == 4) ? s_log[3].cyc : -100000;
        chk("wd_latency", endc - first, 17);
        chk("wd_round", s_round, 0);
        chk("wd_bank_hold", s_bank, 1);
        repeat (3) @(negedge clk);
        chk("wd_no_done", s_done_cnt, dcnt);
        chk("wd_err_sticky", s_err, 1);
        s_hang = '0;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("wd_err_cleared", s_err, 0);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_done) begin ok = 1; break; end
        end
        chk("wd_rerun_done", ok, 1);
        chk("wd_rerun_err", s_err, 0);
        @(negedge clk);

        // Start held high: relaunch right after DONE returns to IDLE
        s_log.delete();
        s_start = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_done) begin ok = 1; break; end
        end
        chk("hold_done", ok, 1);
        chk("hold_nlaunch", s_log.size(), 5);
        @(negedge clk);
        chk("hold_idle", s_ready, 1);
        @(negedge clk);
        s_start = 1'b0;
        chk("hold_relaunch", s_sst, 1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_done) break;
        end

        // Reset mid-operation during WAIT of round 7
        b_L = 3;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (b_round == 7 && b_sst[0]) begin ok = 1; break; end
        end
        chk("mid_reach_r7", ok, 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ready", b_ready, 1);
        chk("mid_rst_sst", b_sst, 0);
        chk("mid_rst_round", b_round, 0);
        chk("mid_rst_bank", b_bank, 0);
        chk("mid_rst_done", b_done, 0);
        chk("mid_rst_err", b_err, 0);
        nlog = b_log.size();
        repeat (10) @(negedge clk);
        chk("mid_rst_no_start", b_log.size(), nlog);
        rst = 1'b1;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("mid_restart_stage", b_sst, 1);
        chk("mid_restart_round", b_round, 0);
        chk("mid_restart_bank", b_bank, 0);
        repeat (5) @(negedge clk);
        chk("mid_second_stage", b_sst, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
